// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - two-entry elastic pipeline stage with registered upstream ready
// Main register drives q; the skid register absorbs one word when downstream stalls.
module pipe_skid_stage #(
  parameter int LENGTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              softReset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] d,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] q,
  output logic [1:0]        count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_n;
  logic              ready_q;
  logic [LENGTH-1:0] main_q;
  logic [LENGTH-1:0] skid_q;
  logic              up_xfer;
  logic              dn_xfer;
  logic              load_main_d;
  logic              load_main_skid;
  logic              load_skid;

  assign out_valid = (state != EMPTY);
  assign in_ready  = ready_q;
  assign q         = main_q;
  assign up_xfer   = in_valid & ready_q;
  assign dn_xfer   = out_valid & out_ready;

  always_comb begin
    state_n        = state;
    load_main_d    = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    count          = 2'd0;
    case (state)
      EMPTY: begin
        count = 2'd0;
        if (up_xfer) begin
          load_main_d = 1'b1;
          state_n     = ONE;
        end
      end
      ONE: begin
        count = 2'd1;
        if (up_xfer && dn_xfer) begin
          load_main_d = 1'b1;
        end else if (up_xfer) begin
          load_skid = 1'b1;
          state_n   = TWO;
        end else if (dn_xfer) begin
          state_n = EMPTY;
        end
      end
      TWO: begin
        count = 2'd2;
        if (dn_xfer) begin
          load_main_skid = 1'b1;
          state_n        = ONE;
        end
      end
      default: begin
        state_n = EMPTY;
      end
    endcase
    // Flush drops any word that would have moved this cycle; data registers keep stale values.
    if (softReset) begin
      state_n        = EMPTY;
      load_main_d    = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state   <= state_n;
      // Ready comes from a flop, so it never follows out_ready within a cycle.
      ready_q <= (state_n != TWO);
      if (load_main_d) begin
        main_q <= d;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= d;
      end
    end
  end

endmodule
